// File: rtl/instr_inv_queue_pkg.sv
// Shared types for instruction-coherency invalidation: cache geometry record and
// the line-address width derived from it. Pure declarations, no timing or flow control.
package cva5_types;

    typedef struct packed {
        int unsigned LINE_W;
        int unsigned LINES;
        int unsigned WAYS;
    } cache_config_t;

    localparam cache_config_t DEFAULT_ICACHE_CONFIG = '{LINE_W: 4, LINES: 512, WAYS: 2};

    // Line is LINE_W 32-bit words, so two extra bits strip the byte offset within a word.
    function automatic int get_line_offset_w(input cache_config_t cfg);
        return $clog2(cfg.LINE_W) + 2;
    endfunction

    localparam int INSTR_INV_LINE_OFFSET_W = get_line_offset_w(DEFAULT_ICACHE_CONFIG);

    typedef logic [32-INSTR_INV_LINE_OFFSET_W-1:0] instr_inv_line_t;

endpackage

// File: rtl/inv_line_fifo.sv
// Circular buffer of line addresses; head is a registered read, valid one cycle after a push.
// No internal backpressure: the caller must not push when full nor pop when empty.
module inv_line_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28,
    localparam int AW = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    // Bypass covers a write landing in the slot that becomes the head this edge.
    assign rd_data_d = (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) ? wr_data
                                                                        : mem_q[rd_ptr_d[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/instr_inv_queue.sv
// Queues store-driven icache/BP line invalidations, merging repeats of the newest untouched line.
// Head offered one cycle after push; inv_ready = !full only; head pops once both consumers acked.
module instr_inv_queue
    import cva5_types::*;
#(
    parameter int DEPTH         = 4,
    parameter int LINE_OFFSET_W = INSTR_INV_LINE_OFFSET_W,
    localparam int LINE_ADDR_W  = 32 - LINE_OFFSET_W,
    localparam int CNT_W        = $clog2(DEPTH) + 1
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inv_valid,
    input  logic [31:0]            inv_addr,
    output logic                   inv_ready,
    output logic                   icache_inv_valid,
    output logic [LINE_ADDR_W-1:0] icache_inv_line,
    input  logic                   icache_inv_ack,
    output logic                   bp_inv_valid,
    output logic [LINE_ADDR_W-1:0] bp_inv_line,
    input  logic                   bp_inv_ack,
    output logic                   empty,
    output logic [CNT_W-1:0]       count
);

    logic [LINE_ADDR_W-1:0] line_in, head_line, last_line_q, last_line_d;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   ic_done_q, ic_done_d, bp_done_q, bp_done_d;
    logic                   last_vld_q, last_vld_d;
    logic                   accept, ic_ack_h, bp_ack_h, head_is_last, merge, push, pop;
    logic                   unused_offset_bits;

    assign line_in            = inv_addr[31:LINE_OFFSET_W];
    assign unused_offset_bits = ^inv_addr[LINE_OFFSET_W-1:0];

    assign icache_inv_valid = !fifo_empty && !ic_done_q;
    assign bp_inv_valid     = !fifo_empty && !bp_done_q;
    assign ic_ack_h         = icache_inv_ack && icache_inv_valid;
    assign bp_ack_h         = bp_inv_ack && bp_inv_valid;

    // The newest entry is the head exactly when it is the only one left.
    assign head_is_last = (fifo_count == CNT_W'(1));
    assign accept       = inv_valid && inv_ready;
    assign merge        = last_vld_q && (line_in == last_line_q)
                          && !(head_is_last && (ic_ack_h || bp_ack_h));
    assign push         = accept && !merge;
    assign pop          = !fifo_empty && (ic_done_q || ic_ack_h) && (bp_done_q || bp_ack_h);

    always_comb begin
        ic_done_d   = ic_done_q || ic_ack_h;
        bp_done_d   = bp_done_q || bp_ack_h;
        last_vld_d  = last_vld_q;
        last_line_d = last_line_q;
        if (pop) begin
            ic_done_d = 1'b0;
            bp_done_d = 1'b0;
        end
        if (head_is_last && (ic_ack_h || bp_ack_h || pop)) begin
            last_vld_d = 1'b0;
        end
        if (push) begin
            last_vld_d  = 1'b1;
            last_line_d = line_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_done_q   <= 1'b0;
            bp_done_q   <= 1'b0;
            last_vld_q  <= 1'b0;
            last_line_q <= '0;
        end else begin
            ic_done_q   <= ic_done_d;
            bp_done_q   <= bp_done_d;
            last_vld_q  <= last_vld_d;
            last_line_q <= last_line_d;
        end
    end

    inv_line_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (line_in),
        .rd_data (head_line),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign inv_ready       = !fifo_full;
    assign icache_inv_line = head_line;
    assign bp_inv_line     = head_line;
    assign empty           = fifo_empty;
    assign count           = fifo_count;

endmodule

// File: tb/tb_instr_inv_queue.sv
// Bench for instr_inv_queue: directed vector table, async-reset sequence, and random traffic
// compared each cycle against a queue-based reference model.
module tb_instr_inv_queue;
    import cva5_types::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            inv_valid = 1'b0;
    logic [31:0]     inv_addr = '0;
    logic            inv_ready;
    logic            icache_inv_valid, bp_inv_valid;
    instr_inv_line_t icache_inv_line, bp_inv_line;
    logic            icache_inv_ack = 1'b0;
    logic            bp_inv_ack = 1'b0;
    logic            empty;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_inv_queue #(.DEPTH(DEPTH), .LINE_OFFSET_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .inv_valid        (inv_valid),
        .inv_addr         (inv_addr),
        .inv_ready        (inv_ready),
        .icache_inv_valid (icache_inv_valid),
        .icache_inv_line  (icache_inv_line),
        .icache_inv_ack   (icache_inv_ack),
        .bp_inv_valid     (bp_inv_valid),
        .bp_inv_line      (bp_inv_line),
        .bp_inv_ack       (bp_inv_ack),
        .empty            (empty),
        .count            (count)
    );

    typedef struct {
        logic        iv;
        logic [31:0] addr;
        logic        ica;
        logic        bpa;
        logic        e_rdy;
        logic        e_icv;
        logic        e_bpv;
        int          e_cnt;
        logic [27:0] e_line;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic iv, logic [31:0] addr, logic ica, logic bpa,
                                logic e_rdy, logic e_icv, logic e_bpv, int e_cnt,
                                logic [27:0] e_line);
        vec_t v;
        v.iv = iv; v.addr = addr; v.ica = ica; v.bpa = bpa;
        v.e_rdy = e_rdy; v.e_icv = e_icv; v.e_bpv = e_bpv; v.e_cnt = e_cnt; v.e_line = e_line;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rdy, input logic e_icv,
                              input logic e_bpv, input int e_cnt, input logic [27:0] e_line);
        chk({tag, ".inv_ready"}, {31'd0, inv_ready}, {31'd0, e_rdy});
        chk({tag, ".icache_valid"}, {31'd0, icache_inv_valid}, {31'd0, e_icv});
        chk({tag, ".bp_valid"}, {31'd0, bp_inv_valid}, {31'd0, e_bpv});
        chk({tag, ".count"}, {29'd0, count}, e_cnt);
        chk({tag, ".empty"}, {31'd0, empty}, {31'd0, e_cnt == 0});
        if (e_icv || e_bpv) begin
            chk({tag, ".icache_line"}, {4'd0, icache_inv_line}, {4'd0, e_line});
            chk({tag, ".bp_line"}, {4'd0, bp_inv_line}, {4'd0, e_line});
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] addr, input logic ica, input logic bpa);
        inv_valid      = iv;
        inv_addr       = addr;
        icache_inv_ack = ica;
        bp_inv_ack     = bpa;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: pending lines in order, per-head done flags, newest-line mergeability.
    logic [27:0] mq[$];
    bit          m_icd, m_bpd, m_mrg;

    task automatic model_reset();
        mq.delete();
        m_icd = 0;
        m_bpd = 0;
        m_mrg = 0;
    endtask

    task automatic model_step(input bit iv, input logic [31:0] addr, input bit ica, input bit bpa);
        int          sz;
        bit          rdy, ich, bph;
        logic [27:0] ln;
        sz  = mq.size();
        rdy = sz < DEPTH;
        ich = ica && sz > 0 && !m_icd;
        bph = bpa && sz > 0 && !m_bpd;
        ln  = addr[31:4];
        if ((ich || bph) && sz == 1) m_mrg = 0;
        if (sz > 0 && (m_icd || ich) && (m_bpd || bph)) begin
            void'(mq.pop_front());
            m_icd = 0;
            m_bpd = 0;
        end else begin
            m_icd = m_icd || ich;
            m_bpd = m_bpd || bph;
        end
        if (mq.size() == 0) m_mrg = 0;
        if (iv && rdy && !(m_mrg && mq[$] == ln)) begin
            mq.push_back(ln);
            m_mrg = 1;
        end
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Directed vectors: inputs held for one cycle, expectations sampled after that edge.
        tbl.push_back(mk(1, 32'h8000_0124, 0, 0, 1, 1, 1, 1, 28'h800_0012));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 28'h0));
        tbl.push_back(mk(1, 32'h0000_1000, 0, 0, 1, 1, 1, 1, 28'h000_0100));
        tbl.push_back(mk(1, 32'h0000_2000, 1, 0, 1, 0, 1, 2, 28'h000_0100));
        tbl.push_back(mk(0, 32'h0,         0, 0, 1, 0, 1, 2, 28'h000_0100));
        tbl.push_back(mk(0, 32'h0,         0, 1, 1, 1, 1, 1, 28'h000_0200));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 28'h0));
        tbl.push_back(mk(1, 32'h8000_0100, 0, 0, 1, 1, 1, 1, 28'h800_0010));
        tbl.push_back(mk(1, 32'h8000_010C, 0, 0, 1, 1, 1, 1, 28'h800_0010));
        tbl.push_back(mk(1, 32'h8000_0110, 0, 0, 1, 1, 1, 2, 28'h800_0010));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 1, 1, 1, 28'h800_0011));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 28'h0));
        tbl.push_back(mk(1, 32'h0000_3000, 0, 0, 1, 1, 1, 1, 28'h000_0300));
        tbl.push_back(mk(0, 32'h0,         1, 0, 1, 0, 1, 1, 28'h000_0300));
        tbl.push_back(mk(1, 32'h0000_3000, 0, 0, 1, 0, 1, 2, 28'h000_0300));
        tbl.push_back(mk(0, 32'h0,         0, 1, 1, 1, 1, 1, 28'h000_0300));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 28'h0));
        tbl.push_back(mk(1, 32'h0000_0100, 0, 0, 1, 1, 1, 1, 28'h000_0010));
        tbl.push_back(mk(1, 32'h0000_0200, 0, 0, 1, 1, 1, 2, 28'h000_0010));
        tbl.push_back(mk(1, 32'h0000_0300, 0, 0, 1, 1, 1, 3, 28'h000_0010));
        tbl.push_back(mk(1, 32'h0000_0400, 0, 0, 0, 1, 1, 4, 28'h000_0010));
        tbl.push_back(mk(1, 32'h0000_0500, 1, 1, 1, 1, 1, 3, 28'h000_0020));
        tbl.push_back(mk(1, 32'h0000_0500, 0, 0, 0, 1, 1, 4, 28'h000_0020));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 1, 1, 3, 28'h000_0030));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 1, 1, 2, 28'h000_0040));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 1, 1, 1, 28'h000_0050));
        tbl.push_back(mk(0, 32'h0,         1, 1, 1, 0, 0, 0, 28'h0));

        do_reset();
        check_outs("reset", 1, 0, 0, 0, 28'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].addr, tbl[i].ica, tbl[i].bpa);
            cycle();
            check_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_icv, tbl[i].e_bpv,
                       tbl[i].e_cnt, tbl[i].e_line);
        end

        // Asynchronous reset with three entries queued and the head half-dispatched.
        drive(1, 32'h0000_1000, 0, 0); cycle();
        drive(1, 32'h0000_2000, 0, 0); cycle();
        drive(1, 32'h0000_3000, 1, 0); cycle();
        check_outs("pre_rst", 1, 0, 1, 3, 28'h000_0100);
        drive(0, '0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 1, 0, 0, 0, 28'h0);
        cycle();
        rst = 1'b0;
        drive(1, 32'h0000_7000, 0, 0); cycle();
        check_outs("post_rst", 1, 1, 1, 1, 28'h000_0700);
        drive(0, '0, 1, 1); cycle();
        check_outs("post_rst_drain", 1, 0, 0, 0, 28'h0);

        // Random traffic over a small line pool so merges and full conditions occur often.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit          iv, ica, bpa;
            logic [31:0] addr;
            iv   = ($urandom_range(0, 99) < 60);
            addr = {28'h800_0000 + 28'($urandom_range(0, 4)), 4'($urandom_range(0, 15))};
            ica  = ($urandom_range(0, 99) < 45);
            bpa  = ($urandom_range(0, 99) < 45);
            drive(iv, addr, ica, bpa);
            model_step(iv, addr, ica, bpa);
            cycle();
            check_outs("rand", mq.size() < DEPTH, mq.size() > 0 && !m_icd,
                       mq.size() > 0 && !m_bpd, mq.size(),
                       (mq.size() > 0) ? mq[0] : 28'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
